// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address stack.
package ras_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned RAS_DEPTH_DEFAULT = 8;

  // Encoded as {push, pop}.
  typedef enum logic [1:0] {
    RAS_NONE = 2'b00,
    RAS_POP  = 2'b01,
    RAS_PUSH = 2'b10,
    RAS_SWAP = 2'b11
  } ras_op_e;

endpackage

// File: rtl/ras_ptr_ctr.sv
// Wrap-around top pointer and saturating live-entry count, with
// registered overflow/underflow pulses.
module ras_ptr_ctr
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  ras_op_e                    op,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   tp,
  output logic [$clog2(DEPTH)-1:0]   tp_m1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] tp_n;
  logic [CW-1:0] count_n;
  logic          overflow_n;
  logic          underflow_n;

  // Next-state decode; flush overrides any push/pop.
  always_comb begin
    tp_n        = tp;
    count_n     = count;
    overflow_n  = 1'b0;
    underflow_n = 1'b0;
    if (flush) begin
      tp_n    = '0;
      count_n = '0;
    end else begin
      unique case (op)
        RAS_PUSH: begin
          tp_n = tp + PW'(1);
          if (count < CW'(DEPTH)) count_n = count + CW'(1);
          else                    overflow_n = 1'b1;
        end
        RAS_POP: begin
          if (count != '0) begin
            tp_n    = tp - PW'(1);
            count_n = count - CW'(1);
          end else begin
            underflow_n = 1'b1;
          end
        end
        RAS_SWAP: begin
          // Swap on an empty stack degenerates to a plain push.
          if (count == '0) begin
            tp_n    = tp + PW'(1);
            count_n = CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tp        <= tp_n;
      count     <= count_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

  assign tp_m1 = tp - PW'(1);

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of link addresses pushed on calls
// and popped on returns, with a predicted return address at top_addr.
module return_addr_stack #(
  parameter int unsigned DEPTH = ras_pkg::RAS_DEPTH_DEFAULT,
  parameter int unsigned XLEN  = ras_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_addr,
  input  logic                     flush,
  output logic [XLEN-1:0]          top_addr,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ras_pkg::ras_op_e op;
  logic [PW-1:0]    tp;
  logic [PW-1:0]    tp_m1;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic [XLEN-1:0]  mem [DEPTH];

  assign op = ras_pkg::ras_op_e'({push, pop});

  ras_ptr_ctr #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .flush     (flush),
    .tp        (tp),
    .tp_m1     (tp_m1),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // A non-empty swap replaces the top entry in place; otherwise write the free slot.
  assign wr_en  = push && !flush;
  assign wr_idx = (pop && (count != '0)) ? tp_m1 : tp;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end

  assign valid    = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign top_addr = valid ? mem[tp_m1] : '0;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack (DEPTH = 8).
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [31:0] push_addr;
  logic        flush;
  logic [31:0] top_addr;
  logic        valid;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  return_addr_stack #(.DEPTH(8), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .flush     (flush),
    .top_addr  (top_addr),
    .valid     (valid),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one operation, let it be sampled on the next rising edge, then idle inputs.
  task automatic do_op(input logic p, input logic q, input logic [31:0] a, input logic f);
    push      = p;
    pop       = q;
    push_addr = a;
    flush     = f;
    @(posedge clk);
    #1;
    push      = 1'b0;
    pop       = 1'b0;
    push_addr = '0;
    flush     = 1'b0;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_top",   top_addr,          32'h0);
    check("rst_valid", 32'(valid),        32'd0);
    check("rst_count", 32'(count),        32'd0);
    check("rst_full",  32'(full),         32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    check("rst_unf",   32'(underflow),    32'd0);
    reset = 1'b1;

    // Pop on empty.
    do_op(1'b0, 1'b1, 32'h0, 1'b0);
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_count", 32'(count),     32'd0);
    do_op(1'b0, 1'b0, 32'h0, 1'b0);
    check("unf_clear", 32'(underflow), 32'd0);

    // LIFO order.
    do_op(1'b1, 1'b0, 32'h104, 1'b0);
    do_op(1'b1, 1'b0, 32'h208, 1'b0);
    do_op(1'b1, 1'b0, 32'h30C, 1'b0);
    check("lifo_top3",   top_addr,   32'h30C);
    check("lifo_count3", 32'(count), 32'd3);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);
    check("lifo_pop1", top_addr, 32'h208);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);
    check("lifo_pop2", top_addr, 32'h104);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);
    check("lifo_pop3",   top_addr,       32'h0);
    check("lifo_valid0", 32'(valid),     32'd0);
    check("lifo_unf",    32'(underflow), 32'd0);

    // Overflow wrap: nine pushes into eight entries.
    for (int i = 0; i < 9; i++) begin
      do_op(1'b1, 1'b0, 32'h10 + 32'(4 * i), 1'b0);
      if (i == 7) begin
        check("ovf_full8", 32'(full),     32'd1);
        check("ovf_none8", 32'(overflow), 32'd0);
      end
    end
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_count", 32'(count),    32'd8);
    check("ovf_top",   top_addr,      32'h30);
    do_op(1'b0, 1'b0, 32'h0, 1'b0);
    check("ovf_clear", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_drain%0d", k), top_addr, 32'h30 - 32'(4 * k));
      do_op(1'b0, 1'b1, 32'h0, 1'b0);
    end
    check("ovf_empty",     32'(valid),     32'd0);
    check("ovf_empty_unf", 32'(underflow), 32'd0);

    // Swap on a two-entry stack.
    do_op(1'b1, 1'b0, 32'h100, 1'b0);
    do_op(1'b1, 1'b0, 32'h200, 1'b0);
    do_op(1'b1, 1'b1, 32'h16AB2D14, 1'b0);
    check("swap_top",   top_addr,   32'h16AB2D14);
    check("swap_count", 32'(count), 32'd2);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);
    check("swap_pop", top_addr, 32'h100);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);

    // Swap on empty behaves as push.
    do_op(1'b1, 1'b1, 32'h55, 1'b0);
    check("swap0_count", 32'(count),     32'd1);
    check("swap0_top",   top_addr,       32'h55);
    check("swap0_unf",   32'(underflow), 32'd0);
    do_op(1'b0, 1'b1, 32'h0, 1'b0);

    // Flush beats push.
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 32'h40 + 32'(i), 1'b0);
    do_op(1'b1, 1'b0, 32'hDEAD, 1'b1);
    check("flush_count", 32'(count),    32'd0);
    check("flush_valid", 32'(valid),    32'd0);
    check("flush_top",   top_addr,      32'h0);
    check("flush_ovf",   32'(overflow), 32'd0);

    // Flush beats push while full: no overflow.
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 32'h80 + 32'(i), 1'b0);
    check("fullfl_full", 32'(full), 32'd1);
    do_op(1'b1, 1'b0, 32'hBEEF, 1'b1);
    check("fullfl_ovf",   32'(overflow), 32'd0);
    check("fullfl_count", 32'(count),    32'd0);

    // Async reset 2 time units before the edge sampling a push.
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0);
    check("arst_pre_count", 32'(count), 32'd5);
    push = 1'b1; push_addr = 32'h11111111;
    #7;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_top",   top_addr,   32'h0);
    check("arst_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    push = 1'b0; push_addr = '0;
    check("arst_hold", 32'(count), 32'd0);
    reset = 1'b1;
    do_op(1'b1, 1'b0, 32'h77, 1'b0);
    check("arst_after_top",   top_addr,   32'h77);
    check("arst_after_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Return-address stack for the single-cycle RV32I core. It records `PCPlus4` when a call (`jal`/`jalr` with rd = x1/x5) retires. On a return (`jalr` with rs1 = x1/x5, rd ≠ rs1) it supplies the predicted return address. This is the read-back counterpart of the link-address write path into the PC. The `jalr_address` leg of `PCNextMux` can compare its ALU result against `top_addr` to count mispredictions.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, 2–64.
- `XLEN`, 32: address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  call retiring this cycle; store `push_addr`.
- `pop`  in  1  return retiring this cycle; discard top entry.
- `push_addr`  in  XLEN  link address (`PCPlus4`) to store.
- `flush`  in  1  synchronous clear of all entries (mispredict/trap).
- `top_addr`  out  XLEN  current top entry; 0 when empty.
- `valid`  out  1  stack non-empty (`top_addr` meaningful).
- `full`  out  1  count == DEPTH.
- `count`  out  $clog2(DEPTH)+1  live entries, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: push while full (oldest entry lost).
- `underflow`  out  1  one-cycle pulse: pop while empty and no push.

## Operation
- Storage is a circular buffer of DEPTH × XLEN registers, with top pointer `tp` (index of the next free slot) and `count`.
- Per-cycle operation decoded from {push, pop}:
  - **none**: hold state.
  - **push**: `mem[tp] <= push_addr`; `tp <= tp+1` (mod DEPTH).
    - If `count < DEPTH`, then `count+1`.
    - Otherwise `count` holds, the oldest entry is overwritten, and `overflow` pulses.
  - **pop**:
    - If `count > 0`, then `tp <= tp-1` (mod DEPTH) and `count-1`.
    - Otherwise no state change and `underflow` pulses.
  - **pop+push** (coroutine swap): `mem[tp-1] <= push_addr`; `tp` and `count` unchanged.
    - If empty, treat as a plain push (count 0→1), with no underflow.
- `flush` has priority over push/pop. It sets `tp <= 0` and `count <= 0`, and both pulses go 0. Memory contents need not clear.
- `top_addr = valid ? mem[tp-1] : 0`. This is combinational from registered state only; there is no input-to-output path.
- `valid = (count != 0)`; `full = (count == DEPTH)`.
- Pointer arithmetic is unsigned, `$clog2(DEPTH)` bits, and wraps naturally. `count` is one bit wider so it can hold DEPTH.
- Reset (async assert, any time including mid-push):
  - `tp = 0`, `count = 0`, `overflow = 0`, `underflow = 0`.
  - Outputs read `top_addr = 0`, `valid = 0`, `full = 0`.
  - Entries are not required to clear.

## Timing
- Push/pop take effect on the rising edge where they are sampled. The new `top_addr`, `count`, `valid` and `full` are visible after that edge (1-cycle latency).
- `overflow`/`underflow` are registered. They are high for exactly the cycle following the offending edge.
- Reset deassertion is synchronized externally. The first operation is accepted on the first rising edge with `reset = 1`.
- `push_addr` must be stable around the rising edge when `push = 1`. It is ignored otherwise.

## Structure
- Package `ras_pkg`:
  - `XLEN` and `RAS_DEPTH_DEFAULT` localparams.
  - Enum `ras_op_e` {RAS_NONE, RAS_PUSH, RAS_POP, RAS_SWAP}, derived from {push, pop}.
- One sub-module, `ras_ptr_ctr`: a wrap-around pointer plus saturating count. Inputs are op, flush and reset. Outputs are `tp`, `tp_m1` and `count`, plus the overflow/underflow detects.
- Storage and read mux stay in `return_addr_stack`.

## Test plan
- **Reset/empty:** reset = 0 for 2 cycles, then release → `top_addr = 0`, `valid = 0`, `count = 0`. Then pop on empty → `underflow` = 1 for one cycle, `count` stays 0.
- **LIFO order:** push 0x00000104, 0x00000208, 0x0000030C on consecutive cycles → `top_addr` = 0x0000030C, `count = 3`. Three pops → `top_addr` reads 0x208, then 0x104, then 0 with `valid = 0`.
- **Overflow wrap (DEPTH = 8):** push 0x10, 0x14, …, 0x30 (9 values) → `overflow` pulses once after the 9th, `full = 1`, `count = 8`, `top_addr` = 0x30. Eight pops return 0x30 down to 0x14 (0x10 lost).
- **Swap:** with the stack holding 0x100, 0x200 (top), assert push+pop with `push_addr` = 0x16AB2D14 → `top_addr` = 0x16AB2D14, `count = 2`. Then pop → `top_addr` = 0x100.
- **Flush vs. push:** 3 entries held; assert `flush` and `push` together → next cycle `count = 0`, `valid = 0`, no overflow.
- **Async reset mid-operation:** while pushing 0x11111111 with `count = 5`, drop reset 2 ns before the edge → `count = 0` and `top_addr = 0` immediately, before any clock edge.
